mac_feeder: RTL and testbench
=============================

MAC_FEEDER -- requirements
Module: mac_feeder

Interface
REQ-001 Parameter TIMEOUT, default 64: max cycles in RUN awaiting mac_done before error.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset (0 = reset asserted).
REQ-004 in_valid  input  1  operand word valid.
REQ-005 in_ready  output  1  feeder accepts in_data this cycle.
REQ-006 in_data  input  16  operand word; frame order is 8 data words, then 8 coefficient words.
REQ-007 d  output  128  to alu_mac: flattened 8x16 data; element i at bits [i*16 +: 16].
REQ-008 cmem  output  128  to alu_mac: flattened 8x16 coefficients; same packing as d.
REQ-009 mac_reset  output  1  to alu_mac reset, active-high; 0 lets alu_mac compute.
REQ-010 mac_out  input  32  alu_mac result.
REQ-011 mac_done  input  1  alu_mac completion.
REQ-012 res_valid  output  1  result available.
REQ-013 res_ready  input  1  consumer accepts result.
REQ-014 res_data  output  32  captured result.
REQ-015 res_err  output  1  result is a timeout, not a valid MAC value.

Function
REQ-016 FSM states LOAD, RUN, RESULT; a word transfer occurs when in_valid & in_ready.
REQ-017 LOAD: in_ready=1, mac_reset=1; a 4-bit word index counts transfers 0..15.
REQ-018 Transfer with index k<8 writes d[k*16 +: 16]; k>=8 writes cmem[(k-8)*16 +: 16]; the index increments per transfer.
REQ-019 Transfer at index 15 moves LOAD->RUN next cycle and clears the index; in_valid gaps anywhere in the frame are tolerated.
REQ-020 RUN and RESULT: in_ready=0; d and cmem held stable.
REQ-021 RUN: mac_reset=0 from the first RUN cycle; the watchdog counter starts at 0 and increments each RUN cycle.
REQ-022 A mac_done rising edge (mac_done=1 with registered previous value 0) in RUN captures mac_out into res_data, sets res_err=0, and moves to RESULT.
REQ-023 Watchdog reaching TIMEOUT without a done edge sets res_data=0 and res_err=1 and moves to RESULT; a done edge in the same cycle wins.
REQ-024 RESULT: res_valid=1, mac_reset=1; res_data and res_err are stable until res_valid & res_ready.
REQ-025 A res_ready handshake moves RESULT->LOAD, clears res_valid, and starts a new frame at index 0; d and cmem keep old values until overwritten.
REQ-026 mac_done while in LOAD or RESULT is ignored.
REQ-027 Latency: first RUN cycle is exactly 1 cycle after the 16th transfer; RESULT is entered 1 cycle after the done edge.

Reset
REQ-028 reset=0 at a rising edge sets: state LOAD, index 0, watchdog 0, registered mac_done 0, d=0, cmem=0, mac_reset=1, res_valid=0, res_data=0, res_err=0.
REQ-029 in_ready=0 while reset=0, and 1 on the first cycle after release.
REQ-030 Reset in any state, mid-frame included, discards partial frame and pending result; no res_valid is produced for that frame.

Structure
REQ-031 Shared package mac_feeder_pkg holds N_ELEM=8, ELEM_W=16, ACC_W=32, and the state enum.
REQ-032 One sub-module, mac_feeder_wdog: loadable up-counter with terminal flag, cleared on RUN entry.
REQ-033 The bench pairs mac_feeder with alu_mac or a behavioural model of alu_mac.

Verification
REQ-034 Frame d=1..8, coef=1 each, model done after 10 cycles -> res_data=36, res_err=0, res_valid until res_ready.
REQ-035 Same frame, res_ready low 5 cycles -> res_valid/res_data stable, in_ready=0, mac_reset=1 throughout.
REQ-036 Model never asserts done, TIMEOUT=64 -> RESULT exactly 64 cycles after RUN entry, res_err=1, res_data=0.
REQ-037 reset=0 after 5 words, then 16 fresh words (d=2, coef=3) -> d/cmem hold only new values, res_data=48.
REQ-038 Random 0-3 cycle in_valid gaps, two back-to-back frames (36 then 48) -> results in order, no lost or duplicated words.
REQ-039 mac_done pulsed during LOAD -> no state change, no res_valid.

Source files
------------

// File: rtl/mac_feeder_pkg.sv
// mac_feeder_pkg
// Shared constants and the control-state type for the MAC operand feeder.
// The geometry is 8 elements of 16 bits for both operand vectors, and a
// 32-bit accumulator result.
package mac_feeder_pkg;

   localparam int N_ELEM = 8;
   localparam int ELEM_W = 16;
   localparam int ACC_W  = 32;
   // Word index covers 2*N_ELEM transfers per frame (data then coefficients).
   localparam int IDX_W  = 4;

   typedef enum logic [1:0] {
      ST_LOAD   = 2'd0,
      ST_RUN    = 2'd1,
      ST_RESULT = 2'd2
   } state_t;

endpackage

// File: rtl/mac_feeder_wdog.sv
// mac_feeder_wdog
// Loadable up-counter used as the RUN watchdog.
// Ports:
//   clk       clock, rising edge
//   reset     synchronous active-low reset (clears the count)
//   load      load load_val this cycle (takes priority over enable)
//   load_val  value loaded on load
//   enable    count up by one this cycle
//   terminal  high in the enabled cycle whose count is TIMEOUT-1, i.e. the
//             cycle in which the watchdog reaches TIMEOUT counted cycles
module mac_feeder_wdog #(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             enable,
   output logic             terminal
);

   logic [CNT_W-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (!reset) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_val;
      end else if (enable) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   // The owner leaves RUN on terminal, so the count never runs past TIMEOUT-1.
   assign terminal = enable && (count_reg == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mac_feeder.sv
// mac_feeder
// Collects one frame of 8 data words followed by 8 coefficient words from a
// valid/ready stream, presents them to an alu_mac, lets it compute, and
// returns its result (or a timeout error) through a valid/ready result port.
// Ports:
//   clk, reset           clock; synchronous active-low reset
//   in_valid/in_ready    operand word handshake, in_data the 16-bit word
//   d, cmem              flattened 8x16 data / coefficient vectors to alu_mac
//   mac_reset            active-high hold for alu_mac (low only in RUN)
//   mac_out, mac_done    alu_mac result and completion
//   res_valid/res_ready  result handshake; res_data result, res_err timeout
module mac_feeder
   import mac_feeder_pkg::*;
#(
   parameter int TIMEOUT = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [ELEM_W-1:0]        in_data,
   output logic [N_ELEM*ELEM_W-1:0] d,
   output logic [N_ELEM*ELEM_W-1:0] cmem,
   output logic                     mac_reset,
   input  logic [ACC_W-1:0]         mac_out,
   input  logic                     mac_done,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [ACC_W-1:0]         res_data,
   output logic                     res_err
);

   localparam int WD_W = $clog2(TIMEOUT + 1);

   state_t             state_reg, state_next;
   logic [IDX_W-1:0]   idx_reg;
   logic               done_prev_reg;
   logic [ACC_W-1:0]   res_data_reg;
   logic               res_err_reg;

   logic               xfer;
   logic               last_word;
   logic               done_edge;
   logic               wd_terminal;

   assign xfer      = in_valid && in_ready;
   assign last_word = xfer && (idx_reg == IDX_W'(2 * N_ELEM - 1));
   assign done_edge = mac_done && !done_prev_reg;

   // Watchdog is zeroed by the transfer that enters RUN, then counts RUN cycles.
   mac_feeder_wdog #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (WD_W)
   ) u_wdog (
      .clk      (clk),
      .reset    (reset),
      .load     (last_word),
      .load_val ('0),
      .enable   (state_reg == ST_RUN),
      .terminal (wd_terminal)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg <= ST_LOAD;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic; a done edge and a watchdog expiry both leave RUN, and
   // the result capture below gives the done edge priority.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_LOAD:   if (last_word)                 state_next = ST_RUN;
         ST_RUN:    if (done_edge || wd_terminal)  state_next = ST_RESULT;
         ST_RESULT: if (res_ready)                 state_next = ST_LOAD;
         default:                                  state_next = ST_LOAD;
      endcase
   end

   // Outputs decoded from state; in_ready is also gated by reset so nothing
   // is accepted while reset is held.
   always_comb begin
      in_ready  = reset && (state_reg == ST_LOAD);
      mac_reset = (state_reg != ST_RUN);
      res_valid = (state_reg == ST_RESULT);
   end

   // Word index, done-edge history and result capture
   always_ff @(posedge clk) begin
      if (!reset) begin
         idx_reg       <= '0;
         done_prev_reg <= 1'b0;
         res_data_reg  <= '0;
         res_err_reg   <= 1'b0;
      end else begin
         done_prev_reg <= mac_done;
         // 4-bit index wraps 15 -> 0 on the last word, starting the next frame at 0.
         if (xfer) begin
            idx_reg <= idx_reg + 1'b1;
         end
         if (state_reg == ST_RUN) begin
            if (done_edge) begin
               res_data_reg <= mac_out;
               res_err_reg  <= 1'b0;
            end else if (wd_terminal) begin
               res_data_reg <= '0;
               res_err_reg  <= 1'b1;
            end
         end
      end
   end

   assign res_data = res_data_reg;
   assign res_err  = res_err_reg;

   // Operand storage: element gi takes word gi (data) and word gi+N_ELEM
   // (coefficient). Writes only happen on transfers, so RUN/RESULT hold them.
   genvar gi;
   generate
      for (gi = 0; gi < N_ELEM; gi++) begin : g_elem
         logic [ELEM_W-1:0] d_elem_reg;
         logic [ELEM_W-1:0] c_elem_reg;

         always_ff @(posedge clk) begin
            if (!reset) begin
               d_elem_reg <= '0;
               c_elem_reg <= '0;
            end else if (xfer) begin
               if (idx_reg == IDX_W'(gi)) begin
                  d_elem_reg <= in_data;
               end
               if (idx_reg == IDX_W'(gi + N_ELEM)) begin
                  c_elem_reg <= in_data;
               end
            end
         end

         assign d[gi*ELEM_W +: ELEM_W]    = d_elem_reg;
         assign cmem[gi*ELEM_W +: ELEM_W] = c_elem_reg;
      end
   endgenerate

endmodule

// File: tb/tb_mac_feeder.sv
// tb_mac_feeder
// Directed bench for mac_feeder paired with a behavioural alu_mac model
// (dot product of d and cmem, done raised a fixed number of RUN cycles in).
module tb_mac_feeder;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [15:0]   in_data = '0;
   logic [127:0]  d;
   logic [127:0]  cmem;
   logic          mac_reset;
   logic [31:0]   mac_out;
   logic          mac_done;
   logic          res_valid;
   logic          res_ready = 1'b0;
   logic [31:0]   res_data;
   logic          res_err;

   int checks = 0;
   int errors = 0;

   // Expected operand vectors, element 0 in the low bits.
   localparam logic [127:0] D1 = {16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
   localparam logic [127:0] C1 = {8{16'd1}};
   localparam logic [127:0] D2 = {8{16'd2}};
   localparam logic [127:0] C3 = {8{16'd3}};

   always #5 clk = ~clk;

   mac_feeder #(.TIMEOUT(64)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .d         (d),
      .cmem      (cmem),
      .mac_reset (mac_reset),
      .mac_out   (mac_out),
      .mac_done  (mac_done),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_err   (res_err)
   );

   // ---------------- behavioural alu_mac ----------------
   logic        mdl_done;
   logic [31:0] mdl_out;
   int          mdl_cnt;
   int          mdl_lat = 10;
   bit          mdl_never = 1'b0;
   logic        force_done = 1'b0;

   assign mac_done = mdl_done | force_done;
   assign mac_out  = mdl_out;

   function automatic logic [31:0] dot8(input logic [127:0] a, input logic [127:0] b);
      logic [31:0] s = '0;
      for (int i = 0; i < 8; i++) s += 32'(a[i*16 +: 16]) * 32'(b[i*16 +: 16]);
      return s;
   endfunction

   always @(posedge clk) begin
      if (mac_reset) begin
         mdl_cnt  <= 0;
         mdl_done <= 1'b0;
      end else begin
         mdl_cnt <= mdl_cnt + 1;
         if (!mdl_never && mdl_cnt == mdl_lat - 1) begin
            mdl_done <= 1'b1;
            mdl_out  <= dot8(d, cmem);
         end
      end
   end

   // ---------------- stimulus helpers (called at a negedge) ----------------
   task automatic send_word(input logic [15:0] w, input int gap);
      int n = 0;
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
      in_valid = 1'b1;
      in_data  = w;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         checks++;
         errors++;
         $display("FAIL send_word: in_ready stuck at %0b, required 1", in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [127:0] dv, input logic [127:0] cv,
                             input int max_gap, input int first, input int last);
      logic [15:0] w;
      for (int k = first; k <= last; k++) begin
         w = (k < 8) ? dv[k*16 +: 16] : cv[(k-8)*16 +: 16];
         send_word(w, (max_gap == 0) ? 0 : int'($urandom_range(max_gap, 0)));
      end
   endtask

   task automatic wait_result(output int n);
      n = 0;
      while (!res_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic handshake();
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %0b required 0", in_ready); end
      checks++; if (mac_reset !== 1'b1) begin errors++; $display("FAIL rst_mac_reset: got %0b required 1", mac_reset); end
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid: got %0b required 0", res_valid); end
      checks++; if (res_data !== 32'd0) begin errors++; $display("FAIL rst_res_data: got %0d required 0", res_data); end
      checks++; if (res_err !== 1'b0) begin errors++; $display("FAIL rst_res_err: got %0b required 0", res_err); end
      checks++; if (d !== 128'd0) begin errors++; $display("FAIL rst_d: got %h required 0", d); end
      checks++; if (cmem !== 128'd0) begin errors++; $display("FAIL rst_cmem: got %h required 0", cmem); end
      reset = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready: got %0b required 1", in_ready); end
      $display("test_reset done");
   endtask

   task automatic test_basic();
      int n;
      send_frame(D1, C1, 0, 0, 15);
      checks++; if (mac_reset !== 1'b0) begin errors++; $display("FAIL basic_run_entry mac_reset: got %0b required 0", mac_reset); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_run in_ready: got %0b required 0", in_ready); end
      checks++; if (d !== D1) begin errors++; $display("FAIL basic_d: got %h required %h", d, D1); end
      checks++; if (cmem !== C1) begin errors++; $display("FAIL basic_cmem: got %h required %h", cmem, C1); end
      wait_result(n);
      checks++; if (n !== 11) begin errors++; $display("FAIL basic_latency: got %0d cycles required 11", n); end
      checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL basic_res_valid: got %0b required 1", res_valid); end
      checks++; if (res_data !== 32'd36) begin errors++; $display("FAIL basic_res_data: got %0d required 36", res_data); end
      checks++; if (res_err !== 1'b0) begin errors++; $display("FAIL basic_res_err: got %0b required 0", res_err); end
      handshake();
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL basic_after_hs res_valid: got %0b required 0", res_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_after_hs in_ready: got %0b required 1", in_ready); end
      $display("test_basic result=%0d err=%0b latency=%0d", res_data, res_err, n);
   endtask

   task automatic test_stall();
      int n;
      send_frame(D1, C1, 0, 0, 15);
      wait_result(n);
      for (int c = 0; c < 5; c++) begin
         checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL stall_res_valid c%0d: got %0b required 1", c, res_valid); end
         checks++; if (res_data !== 32'd36) begin errors++; $display("FAIL stall_res_data c%0d: got %0d required 36", c, res_data); end
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready c%0d: got %0b required 0", c, in_ready); end
         checks++; if (mac_reset !== 1'b1) begin errors++; $display("FAIL stall_mac_reset c%0d: got %0b required 1", c, mac_reset); end
         @(negedge clk);
      end
      handshake();
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL stall_after_hs res_valid: got %0b required 0", res_valid); end
      $display("test_stall result=%0d held 5 cycles", res_data);
   endtask

   task automatic test_timeout();
      int n;
      mdl_never = 1'b1;
      send_frame(D1, C1, 0, 0, 15);
      wait_result(n);
      checks++; if (n !== 64) begin errors++; $display("FAIL timeout_latency: got %0d cycles required 64", n); end
      checks++; if (res_err !== 1'b1) begin errors++; $display("FAIL timeout_res_err: got %0b required 1", res_err); end
      checks++; if (res_data !== 32'd0) begin errors++; $display("FAIL timeout_res_data: got %0d required 0", res_data); end
      checks++; if (d !== D1) begin errors++; $display("FAIL timeout_d_held: got %h required %h", d, D1); end
      handshake();
      mdl_never = 1'b0;
      $display("test_timeout err=%0b after %0d cycles", res_err, n);
   endtask

   task automatic test_reset_midframe();
      int n;
      for (int k = 0; k < 5; k++) send_word(16'(9 + k), 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready: got %0b required 0", in_ready); end
      checks++; if (d !== 128'd0) begin errors++; $display("FAIL midrst_d: got %h required 0", d); end
      reset = 1'b1;
      @(negedge clk);
      send_frame(D2, C3, 0, 0, 15);
      checks++; if (d !== D2) begin errors++; $display("FAIL midrst_new_d: got %h required %h", d, D2); end
      checks++; if (cmem !== C3) begin errors++; $display("FAIL midrst_new_cmem: got %h required %h", cmem, C3); end
      wait_result(n);
      checks++; if (res_data !== 32'd48) begin errors++; $display("FAIL midrst_res_data: got %0d required 48", res_data); end
      checks++; if (res_err !== 1'b0) begin errors++; $display("FAIL midrst_res_err: got %0b required 0", res_err); end
      handshake();
      $display("test_reset_midframe result=%0d", res_data);
   endtask

   task automatic test_back_to_back();
      int n;
      send_frame(D1, C1, 3, 0, 15);
      wait_result(n);
      checks++; if (res_data !== 32'd36) begin errors++; $display("FAIL b2b_first: got %0d required 36", res_data); end
      handshake();
      send_frame(D2, C3, 3, 0, 15);
      checks++; if (d !== D2) begin errors++; $display("FAIL b2b_second_d: got %h required %h", d, D2); end
      wait_result(n);
      checks++; if (res_data !== 32'd48) begin errors++; $display("FAIL b2b_second: got %0d required 48", res_data); end
      checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL b2b_second_valid: got %0b required 1", res_valid); end
      handshake();
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL b2b_no_dup: got %0b required 0", res_valid); end
      $display("test_back_to_back results 36,48 checked");
   endtask

   task automatic test_done_in_load();
      int n;
      send_frame(D1, C1, 0, 0, 2);
      force_done = 1'b1;
      @(negedge clk);
      force_done = 1'b0;
      @(negedge clk);
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL doneload_res_valid: got %0b required 0", res_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL doneload_in_ready: got %0b required 1", in_ready); end
      checks++; if (mac_reset !== 1'b1) begin errors++; $display("FAIL doneload_mac_reset: got %0b required 1", mac_reset); end
      send_frame(D1, C1, 0, 3, 15);
      wait_result(n);
      checks++; if (res_data !== 32'd36) begin errors++; $display("FAIL doneload_res_data: got %0d required 36", res_data); end
      handshake();
      $display("test_done_in_load result=%0d", res_data);
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_basic();
      test_stall();
      test_timeout();
      test_reset_midframe();
      test_back_to_back();
      test_done_in_load();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete, required completion");
      $fatal(1, "global timeout");
   end

endmodule
